// File: rtl/xbus_arb.sv
// Two-master round-robin arbiter for the shared data-memory bus, with bus lock and tagged read return.
// Optional XBUS_ARB_FIXED_PRIO_EN: master 0 always wins contention (lock still overrides).
module xbus_arb #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_sel,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } own_e;

  own_e                lock_own_q, lock_own_d;
  logic                hold0, hold1;
  logic                push_rd;
  logic [READ_LAT-1:0] tag_vld_q;
  logic [READ_LAT-1:0] tag_id_q;
`ifndef XBUS_ARB_FIXED_PRIO_EN
  logic                last_gnt_q, last_gnt_d;
`endif

  always_comb begin
    // A lock only binds while its owner keeps both req and lock asserted.
    hold0  = (lock_own_q == OWN_M0) && m0_req && m0_lock;
    hold1  = (lock_own_q == OWN_M1) && m1_req && m1_lock;
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (hold0) begin
      m0_gnt = 1'b1;
    end else if (hold1) begin
      m1_gnt = 1'b1;
    end else if (m0_req && m1_req) begin
`ifdef XBUS_ARB_FIXED_PRIO_EN
      m0_gnt = 1'b1;
`else
      m0_gnt = last_gnt_q;
      m1_gnt = !last_gnt_q;
`endif
    end else begin
      m0_gnt = m0_req;
      m1_gnt = m1_req;
    end

    lock_own_d = OWN_NONE;
    if (m0_gnt && m0_lock) begin
      lock_own_d = OWN_M0;
    end else if (m1_gnt && m1_lock) begin
      lock_own_d = OWN_M1;
    end
`ifndef XBUS_ARB_FIXED_PRIO_EN
    last_gnt_d = last_gnt_q;
    if (m0_gnt) begin
      last_gnt_d = 1'b0;
    end else if (m1_gnt) begin
      last_gnt_d = 1'b1;
    end
`endif
  end

  always_comb begin
    s_sel   = m0_gnt | m1_gnt;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (m0_gnt) begin
      s_we    = m0_we;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
    end else if (m1_gnt) begin
      s_we    = m1_we;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
    end
    push_rd = s_sel && !s_we;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_own_q <= OWN_NONE;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
    end else begin
      lock_own_q  <= lock_own_d;
      tag_vld_q[0] <= push_rd;
      tag_id_q[0]  <= m1_gnt;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

`ifndef XBUS_ARB_FIXED_PRIO_EN
  // Reset value 1 lets master 0 win the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  assign m0_rvalid = tag_vld_q[READ_LAT-1] && !tag_id_q[READ_LAT-1];
  assign m1_rvalid = tag_vld_q[READ_LAT-1] &&  tag_id_q[READ_LAT-1];
  assign m0_rdata  = m0_rvalid ? s_rdata : '0;
  assign m1_rdata  = m1_rvalid ? s_rdata : '0;

endmodule

// File: tb/tb_xbus_arb.sv
// Scoreboard bench for xbus_arb: two instances (READ_LAT 1 and 3) share stimulus; a spec-level model predicts grants and read returns.
module tb_xbus_arb;

  typedef struct packed {
    logic        req;
    logic        lock;
    logic        we;
    logic [10:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  typedef struct {
    int due;
    int id;
  } rd_ent_t;

  typedef logic [46:0] gv_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  mreq_t       ma = '0;
  mreq_t       mb = '0;
  logic [31:0] s_rdata = '0;

  logic        a_g0, a_g1, a_rv0, a_rv1, a_sel, a_we;
  logic [31:0] a_rd0, a_rd1, a_wd;
  logic [10:0] a_ad;
  logic        b_g0, b_g1, b_rv0, b_rv1, b_sel, b_we;
  logic [31:0] b_rd0, b_rd1, b_wd;
  logic [10:0] b_ad;

  always #5 clk = ~clk;

  xbus_arb #(.ADDR_W(11), .DATA_W(32), .READ_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .m0_req(ma.req), .m0_lock(ma.lock), .m0_we(ma.we), .m0_addr(ma.addr), .m0_wdata(ma.wdata),
    .m0_gnt(a_g0), .m0_rvalid(a_rv0), .m0_rdata(a_rd0),
    .m1_req(mb.req), .m1_lock(mb.lock), .m1_we(mb.we), .m1_addr(mb.addr), .m1_wdata(mb.wdata),
    .m1_gnt(a_g1), .m1_rvalid(a_rv1), .m1_rdata(a_rd1),
    .s_sel(a_sel), .s_we(a_we), .s_addr(a_ad), .s_wdata(a_wd), .s_rdata(s_rdata)
  );

  xbus_arb #(.ADDR_W(11), .DATA_W(32), .READ_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .m0_req(ma.req), .m0_lock(ma.lock), .m0_we(ma.we), .m0_addr(ma.addr), .m0_wdata(ma.wdata),
    .m0_gnt(b_g0), .m0_rvalid(b_rv0), .m0_rdata(b_rd0),
    .m1_req(mb.req), .m1_lock(mb.lock), .m1_we(mb.we), .m1_addr(mb.addr), .m1_wdata(mb.wdata),
    .m1_gnt(b_g1), .m1_rvalid(b_rv1), .m1_rdata(b_rd1),
    .s_sel(b_sel), .s_we(b_we), .s_addr(b_ad), .s_wdata(b_wd), .s_rdata(s_rdata)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] sdat [0:8191];
  gv_t         gq[$];
  rd_ent_t     q1[$];
  rd_ent_t     q3[$];
  int          m_last = 1;
  int          m_own = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic mreq_t mk(input logic req, input logic lock, input logic we,
                               input logic [10:0] addr, input logic [31:0] wdata);
    mreq_t x;
    x.req = req; x.lock = lock; x.we = we; x.addr = addr; x.wdata = wdata;
    return x;
  endfunction

  function automatic mreq_t rnd_req();
    mreq_t x;
    x.req   = ($urandom % 4) != 0;
    x.lock  = ($urandom % 4) == 0;
    x.we    = ($urandom % 2) == 1;
    x.addr  = 11'($urandom);
    x.wdata = $urandom;
    return x;
  endfunction

  // Reference model: owner of a live lock wins; otherwise a lone requester wins;
  // contention goes to whoever was not served last (or master 0 under fixed priority).
  task automatic step(input logic r, input mreq_t a, input mreq_t b, input logic [31:0] rd,
                      output int win);
    mreq_t m[2];
    mreq_t w;
    gv_t   e;
    @(posedge clk);
    #1;
    rst = r; ma = a; mb = b; s_rdata = rd;
    sdat[cyc] = rd;
    m[0] = a; m[1] = b;
    if (r) begin
      m_last = 1; m_own = -1;
      q1.delete(); q3.delete();
    end
    win = -1;
    if (m_own >= 0 && m[m_own].req && m[m_own].lock) win = m_own;
    else if (a.req && b.req) begin
`ifdef XBUS_ARB_FIXED_PRIO_EN
      win = 0;
`else
      win = 1 - m_last;
`endif
    end
    else if (a.req) win = 0;
    else if (b.req) win = 1;
    w = (win >= 0) ? m[win] : '0;
    e = {win == 0, win == 1, win >= 0, w.we, w.addr, w.wdata};
    gq.push_back(e);
    if (!r) begin
      m_own = (win >= 0 && w.lock) ? win : -1;
      if (win >= 0) begin
        m_last = win;
        if (!w.we) begin
          q1.push_back('{cyc + 1, win});
          q3.push_back('{cyc + 3, win});
        end
      end
    end
  endtask

  task automatic chk_rd(input int k, input logic v0, input logic v1,
                        input logic [31:0] d0, input logic [31:0] d1);
    rd_ent_t     en;
    logic        have;
    logic        ev0, ev1;
    logic [31:0] ed0, ed1;
    have = 1'b0;
    en = '{0, 0};
    if (k == 0 && q1.size() > 0 && q1[0].due == cyc) begin en = q1.pop_front(); have = 1'b1; end
    if (k == 1 && q3.size() > 0 && q3[0].due == cyc) begin en = q3.pop_front(); have = 1'b1; end
    if (have || v0 || v1) begin
      ev0 = have && en.id == 0;
      ev1 = have && en.id == 1;
      ed0 = ev0 ? sdat[cyc] : 32'h0;
      ed1 = ev1 ? sdat[cyc] : 32'h0;
      total++;
      if ({v0, v1, d0, d1} !== {ev0, ev1, ed0, ed1}) begin
        bad++;
        $display("FAIL rdret lat=%0d cyc=%0d got v=%b%b d0=%h d1=%h exp v=%b%b d0=%h d1=%h",
                 (k == 0) ? 1 : 3, cyc, v0, v1, d0, d1, ev0, ev1, ed0, ed1);
      end
    end
  endtask

  always @(negedge clk) begin
    gv_t e, g1, g3;
    if (gq.size() > 0) begin
      e  = gq.pop_front();
      g1 = {a_g0, a_g1, a_sel, a_we, a_ad, a_wd};
      g3 = {b_g0, b_g1, b_sel, b_we, b_ad, b_wd};
      total++;
      if (g1 !== e || g3 !== e) begin
        bad++;
        $display("FAIL grant cyc=%0d got=%h/%h exp=%h", cyc, g1, g3, e);
      end
      chk_rd(0, a_rv0, a_rv1, a_rd0, a_rd1);
      chk_rd(1, b_rv0, b_rv1, b_rd0, b_rd1);
    end
  end

  initial begin
    int    w;
    logic  r;
    mreq_t idle, c0, c1, lk, rb;
    idle = '0;
    step(1'b1, idle, idle, 32'h0, w);
    step(1'b1, idle, idle, 32'h0, w);
    // both masters read back to back: alternate, data routed in order
    step(1'b0, mk(1, 0, 0, 11'h1, 0), mk(1, 0, 0, 11'h2, 0), 32'h0, w);
    step(1'b0, mk(1, 0, 0, 11'h1, 0), mk(1, 0, 0, 11'h2, 0), 32'hA0, w);
    step(1'b0, mk(1, 0, 0, 11'h1, 0), mk(1, 0, 0, 11'h2, 0), 32'hA1, w);
    step(1'b0, mk(1, 0, 0, 11'h1, 0), mk(1, 0, 0, 11'h2, 0), 32'hA2, w);
    step(1'b0, idle, idle, 32'hA3, w);
    // lone write from master 1
    step(1'b0, idle, mk(1, 0, 1, 11'h10, 32'h55), 32'h0, w);
    step(1'b0, idle, idle, 32'h77, w);
    step(1'b0, idle, idle, 32'h78, w);
    step(1'b0, idle, idle, 32'h79, w);
    // master 0 locks the bus, then releases while still requesting
    lk = mk(1, 1, 0, 11'h20, 0);
    rb = mk(1, 0, 0, 11'h30, 0);
    for (int i = 0; i < 3; i++) step(1'b0, lk, rb, $urandom, w);
    step(1'b0, mk(1, 0, 0, 11'h21, 0), rb, $urandom, w);
    step(1'b0, idle, idle, $urandom, w);
    // master 1 lock blocks a lone master 0
    step(1'b0, idle, mk(1, 1, 1, 11'h40, 32'h9), $urandom, w);
    step(1'b0, mk(1, 0, 0, 11'h41, 0), mk(1, 1, 0, 11'h42, 0), $urandom, w);
    step(1'b0, mk(1, 0, 0, 11'h41, 0), idle, $urandom, w);
    // read then reset before it returns: dropped on both latencies
    step(1'b0, mk(1, 0, 0, 11'h5, 0), idle, $urandom, w);
    step(1'b1, idle, idle, $urandom, w);
    step(1'b1, idle, idle, $urandom, w);
    for (int i = 0; i < 4; i++) step(1'b0, idle, idle, $urandom, w);
    // continuous contention
    for (int i = 0; i < 5; i++)
      step(1'b0, mk(1, 0, 0, 11'h6, 0), mk(1, 0, 0, 11'h7, 0), $urandom, w);
    for (int i = 0; i < 3; i++) step(1'b0, idle, idle, $urandom, w);
    // randomized traffic with occasional reset; fields held until granted
    c0 = rnd_req();
    c1 = rnd_req();
    for (int i = 0; i < 600; i++) begin
      r = ($urandom % 97) == 0;
      step(r, c0, c1, $urandom, w);
      if (r || w == 0 || !c0.req) c0 = rnd_req();
      if (r || w == 1 || !c1.req) c1 = rnd_req();
    end
    for (int i = 0; i < 6; i++) step(1'b0, idle, idle, $urandom, w);
    @(negedge clk);
    #1;
    total++;
    if (q1.size() != 0 || q3.size() != 0 || gq.size() != 0) begin
      bad++;
      $display("FAIL drain pending q1=%0d q3=%0d gq=%0d expected all 0", q1.size(), q3.size(), gq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
